// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants and types for the PS/2-to-GBA keypad path.
//   - KEYINPUT bit positions for every GBA button
//   - PS/2 set-2 scan codes used by the decoder (base, extended, prefixes)
//   - decoder FSM state encoding and the scan-code lookup helpers
package keypad_pkg;

  // KEYINPUT bit positions (active-low vector, 0 = pressed)
  localparam int KEY_A      = 0;
  localparam int KEY_B      = 1;
  localparam int KEY_SELECT = 2;
  localparam int KEY_START  = 3;
  localparam int KEY_RIGHT  = 4;
  localparam int KEY_LEFT   = 5;
  localparam int KEY_UP     = 6;
  localparam int KEY_DOWN   = 7;
  localparam int KEY_R      = 8;
  localparam int KEY_L      = 9;
  localparam int NUM_KEYS   = 10;

  // Base scan codes
  localparam logic [7:0] SC_J = 8'h3B;
  localparam logic [7:0] SC_K = 8'h42;
  localparam logic [7:0] SC_N = 8'h31;
  localparam logic [7:0] SC_M = 8'h3A;
  localparam logic [7:0] SC_D = 8'h23;
  localparam logic [7:0] SC_A = 8'h1C;
  localparam logic [7:0] SC_W = 8'h1D;
  localparam logic [7:0] SC_S = 8'h1B;
  localparam logic [7:0] SC_I = 8'h43;
  localparam logic [7:0] SC_U = 8'h3C;

  // Extended (E0-prefixed) arrow codes
  localparam logic [7:0] SC_X_RIGHT = 8'h74;
  localparam logic [7:0] SC_X_LEFT  = 8'h6B;
  localparam logic [7:0] SC_X_UP    = 8'h75;
  localparam logic [7:0] SC_X_DOWN  = 8'h72;

  // Prefix bytes
  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } lookup_t;

  function automatic lookup_t base_lookup(input logic [7:0] code);
    lookup_t r;
    r.hit = 1'b1;
    r.idx = 4'd0;
    case (code)
      SC_J:    r.idx = 4'(KEY_A);
      SC_K:    r.idx = 4'(KEY_B);
      SC_N:    r.idx = 4'(KEY_SELECT);
      SC_M:    r.idx = 4'(KEY_START);
      SC_D:    r.idx = 4'(KEY_RIGHT);
      SC_A:    r.idx = 4'(KEY_LEFT);
      SC_W:    r.idx = 4'(KEY_UP);
      SC_S:    r.idx = 4'(KEY_DOWN);
      SC_I:    r.idx = 4'(KEY_R);
      SC_U:    r.idx = 4'(KEY_L);
      default: r.hit = 1'b0;
    endcase
    return r;
  endfunction

  function automatic lookup_t ext_lookup(input logic [7:0] code);
    lookup_t r;
    r.hit = 1'b1;
    r.idx = 4'd0;
    case (code)
      SC_X_RIGHT: r.idx = 4'(KEY_RIGHT);
      SC_X_LEFT:  r.idx = 4'(KEY_LEFT);
      SC_X_UP:    r.idx = 4'(KEY_UP);
      SC_X_DOWN:  r.idx = 4'(KEY_DOWN);
      default:    r.hit = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_keypad_if.sv
// ps2_keypad_if: bundle of the keypad block's external signals.
//   master: drives the raw PS/2 lines and scan_en, observes the keypad outputs.
//   slave : the keypad block itself.
//   ps2_clk/ps2_data : raw asynchronous PS/2 lines
//   scan_en          : 1 lets the decoder drain the scan-byte FIFO
//   keys_n           : active-low KEYINPUT vector
//   key_event/key_code/key_pressed : one-cycle decoded key event
//   frame_err        : one-cycle pulse on a bad frame or timeout
//   overflow         : sticky FIFO-drop flag
//   dbg_state        : current decoder FSM state
interface ps2_keypad_if;
  import keypad_pkg::*;

  logic       ps2_clk;
  logic       ps2_data;
  logic       scan_en;
  logic [9:0] keys_n;
  logic       key_event;
  logic [3:0] key_code;
  logic       key_pressed;
  logic       frame_err;
  logic       overflow;
  dec_state_t dbg_state;

  modport master (
    output ps2_clk, ps2_data, scan_en,
    input  keys_n, key_event, key_code, key_pressed, frame_err, overflow, dbg_state
  );

  modport slave (
    input  ps2_clk, ps2_data, scan_en,
    output keys_n, key_event, key_code, key_pressed, frame_err, overflow, dbg_state
  );
endinterface

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with scan-byte FIFO.
//   clk, clrn     : system clock, asynchronous active-low reset
//   ps2_clk_i     : raw PS/2 clock (3-flop synchronised, falling edge sampled)
//   ps2_data_i    : raw PS/2 data (2-flop synchronised)
//   pop_i         : consumer takes byte_o this cycle (ignored when empty)
//   byte_o        : oldest buffered scan byte
//   empty_o       : FIFO holds no bytes
//   frame_err_o   : one-cycle pulse after a bad frame or a frame timeout
//   overflow_o    : sticky; an accepted byte was dropped because the FIFO was full
// Handshake: !empty_o acts as valid and pop_i as ready; a byte transfers in
// every cycle where both are high, and byte_o is held stable until then.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  input  logic       pop_i,
  output logic [7:0] byte_o,
  output logic       empty_o,
  output logic       frame_err_o,
  output logic       overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] IDLE_MAX = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] IDLE_ONE = CW'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);

  // Synchronisers reset to the idle-high line level so reset never fakes an edge
  logic [2:0] clk_sync_q;
  logic [1:0] dat_sync_q;
  logic       sample;
  logic       data_s;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_q <= 3'b111;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_data_i};
    end
  end

  assign sample = clk_sync_q[2] & ~clk_sync_q[1];
  assign data_s = dat_sync_q[1];

  // Frame receiver and timeout
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [CW-1:0] idle_q, idle_d;
  logic          ferr_q, ferr_d;
  logic [10:0]   frame;
  logic          push;

  // The 11th bit is never shifted in; the full frame is formed on the fly
  assign frame = {data_s, shift_q};

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    idle_d    = idle_q;
    ferr_d    = 1'b0;
    push      = 1'b0;
    if (sample) begin
      idle_d = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
        // start=0, stop=1, and the 8 data bits plus parity hold an odd count of ones
        if (!frame[0] && frame[10] && (^frame[9:1])) push = 1'b1;
        else                                         ferr_d = 1'b1;
      end else begin
        shift_d   = {data_s, shift_q[9:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q == 4'd0) begin
      idle_d = '0;
    end else if (idle_q == IDLE_MAX) begin
      bit_cnt_d = 4'd0;
      idle_d    = '0;
      ferr_d    = 1'b1;
    end else begin
      idle_d = idle_q + IDLE_ONE;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bit_cnt_q <= 4'd0;
      shift_q   <= '0;
      idle_q    <= '0;
      ferr_q    <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      idle_q    <= idle_d;
      ferr_q    <= ferr_d;
    end
  end

  assign frame_err_o = ferr_q;

  // FIFO: pointers carry one wrap bit above the index bits
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        ovf_q, ovf_d;
  logic        full, empty, do_pop, do_push;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push && !do_push) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: contents are only read behind a valid pointer
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= frame[8:1];
  end

  assign byte_o     = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o    = empty;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/ps2_keypad.sv
// ps2_keypad: PS/2 keyboard front end producing the GBA KEYINPUT vector.
//   clk, clrn : system clock, asynchronous active-low reset
//   bus       : ps2_keypad_if.slave
//     in : ps2_clk, ps2_data (raw), scan_en (decoder may drain FIFO)
//     out: keys_n, key_event, key_code, key_pressed, frame_err, overflow, dbg_state
// The receiver/FIFO lives in ps2_rx_fifo; this level decodes make/break
// sequences (with E0-extended arrows when EXT_MAP=1) into keys_n and events.
module ps2_keypad
  import keypad_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int EXT_MAP        = 1
) (
  input  logic         clk,
  input  logic         clrn,
  ps2_keypad_if.slave  bus
);

  logic [7:0] fifo_byte;
  logic       fifo_empty;
  logic       pop;

  ps2_rx_fifo #(
    .FIFO_DEPTH     (FIFO_DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk         (clk),
    .clrn        (clrn),
    .ps2_clk_i   (bus.ps2_clk),
    .ps2_data_i  (bus.ps2_data),
    .pop_i       (pop),
    .byte_o      (fifo_byte),
    .empty_o     (fifo_empty),
    .frame_err_o (bus.frame_err),
    .overflow_o  (bus.overflow)
  );

  // One byte per cycle whenever allowed; dropping scan_en stops this same cycle
  assign pop = !fifo_empty && bus.scan_en;

  dec_state_t  state_q, state_d;
  logic [9:0]  keys_q, keys_d;
  logic        event_q, event_d;
  logic [3:0]  code_q, code_d;
  logic        pressed_q, pressed_d;
  lookup_t     lk;
  logic        do_lk;
  logic        make;

  always_comb begin
    state_d   = state_q;
    keys_d    = keys_q;
    event_d   = 1'b0;
    code_d    = code_q;
    pressed_d = pressed_q;
    lk        = '0;
    do_lk     = 1'b0;
    make      = 1'b0;
    if (pop) begin
      case (state_q)
        ST_IDLE: begin
          if (fifo_byte == SC_BRK)      state_d = ST_BRK;
          else if (fifo_byte == SC_EXT) state_d = ST_EXT;
          else begin
            lk    = base_lookup(fifo_byte);
            do_lk = 1'b1;
            make  = 1'b1;
          end
        end
        ST_BRK: begin
          lk      = base_lookup(fifo_byte);
          do_lk   = 1'b1;
          state_d = ST_IDLE;
        end
        ST_EXT: begin
          if (fifo_byte == SC_BRK) state_d = ST_EXT_BRK;
          else begin
            if (EXT_MAP != 0) lk = ext_lookup(fifo_byte);
            do_lk   = 1'b1;
            make    = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          if (EXT_MAP != 0) lk = ext_lookup(fifo_byte);
          do_lk   = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // Events fire even when the bit already holds the target value (typematic repeat)
    if (do_lk && lk.hit) begin
      keys_d[lk.idx] = ~make;
      event_d        = 1'b1;
      code_d         = lk.idx;
      pressed_d      = make;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= ST_IDLE;
      keys_q    <= 10'h3FF;
      event_q   <= 1'b0;
      code_q    <= 4'd0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      keys_q    <= keys_d;
      event_q   <= event_d;
      code_q    <= code_d;
      pressed_q <= pressed_d;
    end
  end

  assign bus.keys_n      = keys_q;
  assign bus.key_event   = event_q;
  assign bus.key_code    = code_q;
  assign bus.key_pressed = pressed_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_ps2_keypad.sv
// tb_ps2_keypad: drives PS/2 frames into two keypad instances (EXT_MAP=1 and
// EXT_MAP=0) and checks decoded events, keys_n, frame errors and overflow
// against a scan-code reference model kept in this bench.
module tb_ps2_keypad;
  import keypad_pkg::*;

  localparam int DEPTH = 8;
  localparam int TMO   = 400;

  logic clk;
  logic clrn;
  logic ps2_clk;
  logic ps2_data;
  logic scan_en;

  ps2_keypad_if bus1 ();
  ps2_keypad_if bus0 ();

  assign bus1.ps2_clk  = ps2_clk;
  assign bus1.ps2_data = ps2_data;
  assign bus1.scan_en  = scan_en;
  assign bus0.ps2_clk  = ps2_clk;
  assign bus0.ps2_data = ps2_data;
  assign bus0.scan_en  = scan_en;

  ps2_keypad #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .EXT_MAP(1)) dut1 (
    .clk(clk), .clrn(clrn), .bus(bus1));
  ps2_keypad #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .EXT_MAP(0)) dut0 (
    .clk(clk), .clrn(clrn), .bus(bus0));

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters ----------------
  int vectors    = 0;
  int miscompares = 0;

  // ---------------- monitor ----------------
  logic [4:0] got1_q[$];
  logic [4:0] got0_q[$];
  int ferr1 = 0;
  int ferr0 = 0;

  always @(negedge clk) begin
    if (bus1.key_event) got1_q.push_back({bus1.key_pressed, bus1.key_code});
    if (bus0.key_event) got0_q.push_back({bus0.key_pressed, bus0.key_code});
    if (bus1.frame_err) ferr1++;
    if (bus0.frame_err) ferr0++;
  end

  // ---------------- reference model ----------------
  logic [7:0] base_tab[10] = '{8'h3B, 8'h42, 8'h31, 8'h3A, 8'h23,
                               8'h1C, 8'h1D, 8'h1B, 8'h43, 8'h3C};
  logic [7:0] ext_tab[4]   = '{8'h74, 8'h6B, 8'h75, 8'h72};  // bits 4..7

  logic [4:0] exp1_q[$];
  logic [4:0] exp0_q[$];
  logic [7:0] pend_q[$];
  logic [9:0] m_keys[2];
  bit         m_brk[2];
  bit         m_ext[2];
  bit         hold;
  logic       exp_ovf;
  int         exp_ferr;

  function automatic int base_idx(input logic [7:0] b);
    for (int i = 0; i < 10; i++) if (base_tab[i] == b) return i;
    return -1;
  endfunction

  function automatic int ext_idx(input logic [7:0] b);
    for (int i = 0; i < 4; i++) if (ext_tab[i] == b) return i + 4;
    return -1;
  endfunction

  // w selects the model copy: 1 = arrows mapped, 0 = extended codes ignored
  task automatic model_byte(input int w, input logic [7:0] b);
    int idx;
    bit mk;
    idx = -1;
    mk  = 1'b0;
    if (!m_brk[w] && !m_ext[w]) begin
      if (b == 8'hF0)      m_brk[w] = 1'b1;
      else if (b == 8'hE0) m_ext[w] = 1'b1;
      else begin idx = base_idx(b); mk = 1'b1; end
    end else if (m_ext[w] && !m_brk[w]) begin
      if (b == 8'hF0) m_brk[w] = 1'b1;
      else begin
        idx = (w == 1) ? ext_idx(b) : -1;
        mk = 1'b1;
        m_ext[w] = 1'b0;
      end
    end else begin
      idx = m_ext[w] ? ((w == 1) ? ext_idx(b) : -1) : base_idx(b);
      mk = 1'b0;
      m_brk[w] = 1'b0;
      m_ext[w] = 1'b0;
    end
    if (idx >= 0) begin
      m_keys[w][idx] = ~mk;
      if (w == 1) exp1_q.push_back({mk, 4'(idx)});
      else        exp0_q.push_back({mk, 4'(idx)});
    end
  endtask

  task automatic model_feed(input logic [7:0] b);
    if (hold) begin
      if (pend_q.size() < DEPTH) pend_q.push_back(b);
      else exp_ovf = 1'b1;
    end else begin
      model_byte(1, b);
      model_byte(0, b);
    end
  endtask

  task automatic model_release();
    hold = 1'b0;
    while (pend_q.size() > 0) model_feed(pend_q.pop_front());
  endtask

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      m_keys[w] = 10'h3FF;
      m_brk[w]  = 1'b0;
      m_ext[w]  = 1'b0;
    end
    exp_ovf = 1'b0;
    pend_q.delete();
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " ev1_count"}, got1_q.size(), exp1_q.size());
    while (got1_q.size() > 0 && exp1_q.size() > 0)
      check({tag, " ev1"}, {27'd0, got1_q.pop_front()}, {27'd0, exp1_q.pop_front()});
    check({tag, " ev0_count"}, got0_q.size(), exp0_q.size());
    while (got0_q.size() > 0 && exp0_q.size() > 0)
      check({tag, " ev0"}, {27'd0, got0_q.pop_front()}, {27'd0, exp0_q.pop_front()});
    got1_q.delete(); exp1_q.delete(); got0_q.delete(); exp0_q.delete();
    check({tag, " keys1"}, {22'd0, bus1.keys_n}, {22'd0, m_keys[1]});
    check({tag, " keys0"}, {22'd0, bus0.keys_n}, {22'd0, m_keys[0]});
    check({tag, " ferr1"}, ferr1, exp_ferr);
    check({tag, " ferr0"}, ferr0, exp_ferr);
    check({tag, " ovf1"}, {31'd0, bus1.overflow}, {31'd0, exp_ovf});
    check({tag, " ovf0"}, {31'd0, bus0.overflow}, {31'd0, exp_ovf});
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " keys_n"}, {22'd0, bus1.keys_n}, 32'h3FF);
    check({tag, " key_event"}, {31'd0, bus1.key_event}, 32'd0);
    check({tag, " key_code"}, {28'd0, bus1.key_code}, 32'd0);
    check({tag, " key_pressed"}, {31'd0, bus1.key_pressed}, 32'd0);
    check({tag, " frame_err"}, {31'd0, bus1.frame_err}, 32'd0);
    check({tag, " overflow"}, {31'd0, bus1.overflow}, 32'd0);
    check({tag, " state"}, {30'd0, bus1.dbg_state}, {30'd0, ST_IDLE});
    check({tag, " keys_n0"}, {22'd0, bus0.keys_n}, 32'h3FF);
  endtask

  // ---------------- PS/2 drivers ----------------
  // Data changes while the line clock is high; chk verifies event latency on this bit
  task automatic send_bit(input logic b, input bit chk);
    @(negedge clk);
    ps2_data = b;
    repeat (8) @(negedge clk);
    ps2_clk = 1'b0;
    if (chk) begin
      repeat (3) @(negedge clk);
      check("latency_early", {31'd0, bus1.key_event}, 32'd0);
      @(negedge clk);
      check("latency_event", {31'd0, bus1.key_event}, 32'd1);
      repeat (11) @(negedge clk);
    end else begin
      repeat (15) @(negedge clk);
    end
    ps2_clk = 1'b1;
    repeat (7) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit chk);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
    send_bit((~^b) ^ bad_par, 1'b0);
    send_bit(1'b1, chk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0);
    model_feed(b);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b;
    logic [7:0] misc_tab[3];
    misc_tab = '{8'hAA, 8'hFA, 8'hE1};
    clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; scan_en = 1'b1;
    hold = 1'b0; exp_ferr = 0;
    model_reset();
    settle(5);
    check_reset_vals("in_reset");
    clrn = 1'b1;
    settle(5);
    check_reset_vals("after_reset");

    // make of A-key, with exact pipeline latency, then its break
    send_frame(8'h1C, 1'b0, 1'b1);
    model_feed(8'h1C);
    settle(10);
    check("make_1c keys", {22'd0, bus1.keys_n}, 32'h3DF);
    check("make_1c pressed", {31'd0, bus1.key_pressed}, 32'd1);
    check("make_1c code", {28'd0, bus1.key_code}, 32'd5);
    check_all("make_1c");
    send_byte(8'hF0); send_byte(8'h1C);
    settle(10);
    check("brk_1c keys", {22'd0, bus1.keys_n}, 32'h3FF);
    check_all("brk_1c");

    // extended Up make and break
    send_byte(8'hE0); send_byte(8'h75);
    settle(10);
    check("ext_up keys1", {22'd0, bus1.keys_n}, 32'h3BF);
    check("ext_up keys0", {22'd0, bus0.keys_n}, 32'h3FF);
    check_all("ext_make");
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    settle(10);
    check_all("ext_brk");

    // bad parity frame then J
    send_frame(8'h3B, 1'b1, 1'b0);
    exp_ferr++;
    send_byte(8'h3B);
    settle(10);
    check("parity keys", {22'd0, bus1.keys_n}, 32'h3FE);
    check_all("parity");

    // partial frame abandoned by timeout, then K
    send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    settle(TMO + 10);
    exp_ferr++;
    send_byte(8'h42);
    settle(10);
    check_all("timeout");

    // overflow with decoder paused
    @(negedge clk); scan_en = 1'b0; hold = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) send_byte(8'h3A);
    settle(10);
    check_all("ovf_paused");
    @(negedge clk); scan_en = 1'b1;
    model_release();
    settle(30);
    check_all("ovf_drain");

    // randomized scan-code stream
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0, 1:    b = base_tab[$urandom_range(0, 9)];
        2:       b = 8'hF0;
        3:       b = 8'hE0;
        4:       b = ext_tab[$urandom_range(0, 3)];
        default: b = ($urandom_range(0, 1) == 0) ? misc_tab[$urandom_range(0, 2)]
                                                 : 8'($urandom_range(0, 255));
      endcase
      send_byte(b);
      settle($urandom_range(0, 20));
      if (i % 10 == 9) begin
        settle(10);
        check_all("random");
      end
    end

    // reset between F0 and I, with a partial frame in flight
    send_byte(8'hF0);
    send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    @(negedge clk); clrn = 1'b0;
    settle(3);
    model_reset();
    got1_q.delete(); got0_q.delete(); exp1_q.delete(); exp0_q.delete();
    check_reset_vals("mid_reset");
    clrn = 1'b1;
    settle(5);
    send_byte(8'h43);
    settle(10);
    check("reset_43 keys", {22'd0, bus1.keys_n}, 32'h2FF);
    check_all("reset_43");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
